alarm_controller: RTL and testbench



---
 rtl/alarm_pkg.sv | 21 ++
 rtl/alarm_sec_timer.sv | 29 ++
 rtl/alarm_controller.sv | 143 ++++++++++++++
 tb/tb_alarm_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm controller: state encoding,
// timer width and the default ring/snooze lengths.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } alarm_state_e;

    localparam int TIMER_W         = 10;
    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 540;
    localparam int MAX_SNOOZE_DEF  = 3;

    // A reload value must be nonzero and representable in the down-counter.
    function automatic bit fits_timer(input int secs);
        return (secs > 0) && (secs < (1 << TIMER_W));
    endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter; expire flags the tick that takes it from 1 to 0.
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               sec_tick,
    output logic [TIMER_W-1:0] count,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (sec_tick && (count_q != '0)) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign count  = count_q;
    assign expire = sec_tick && (count_q == TIMER_W'(1));

endmodule

// File: rtl/alarm_controller.sv
// Alarm compare, ring/snooze sequencing and buzzer drive for the 12-hour clock.
//   state   | meaning
//   IDLE    | armed or disarmed, waiting for the time to reach the alarm
//   RINGING | buzzer toggling at 1 Hz until stop, snooze or timeout
//   SNOOZE  | buzzer silent, counting down to the next ring
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [3:0] cur_hr_tens,
    input  logic [3:0] cur_hr_ones,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    input  logic       cur_pm,
    input  logic [3:0] alm_hr_tens,
    input  logic [3:0] alm_hr_ones,
    input  logic [3:0] alm_min_tens,
    input  logic [3:0] alm_min_ones,
    input  logic       alm_pm,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    if (!fits_timer(RING_SECS) || !fits_timer(SNOOZE_SECS)
        || (MAX_SNOOZE < 0) || (MAX_SNOOZE > 3)) begin : g_param_check
        $error("alarm_controller: RING_SECS/SNOOZE_SECS must fit TIMER_W, MAX_SNOOZE must fit 2 bits");
    end

    alarm_state_e       state_q;
    logic               buzzer_q;
    logic [1:0]         snooze_cnt_q;
    logic               match_d_q;
    logic               match;
    logic               trigger;
    logic               stop_req;
    logic               snooze_ok;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic [TIMER_W-1:0] timer_cnt;
    logic               timer_expire;

    assign match = alarm_en
                && (cur_hr_tens  == alm_hr_tens)
                && (cur_hr_ones  == alm_hr_ones)
                && (cur_min_tens == alm_min_tens)
                && (cur_min_ones == alm_min_ones)
                && (cur_pm == alm_pm);

    assign trigger   = match && !match_d_q;
    assign stop_req  = !alarm_en || stop_btn;
    assign snooze_ok = snooze_btn && (int'(snooze_cnt_q) < MAX_SNOOZE);

    // Reload on every entry into RINGING or SNOOZE, mirroring the FSM branches below.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = TIMER_W'(RING_SECS);
        case (state_q)
            IDLE:    timer_load = trigger;
            RINGING: begin
                timer_load = !stop_req && snooze_ok;
                timer_val  = TIMER_W'(SNOOZE_SECS);
            end
            SNOOZE:  timer_load = !stop_req && timer_expire;
            default: timer_load = 1'b0;
        endcase
    end

    alarm_sec_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .sec_tick (sec_tick),
        .count    (timer_cnt),
        .expire   (timer_expire)
    );

    // match_d resets high so a power-up match at 12:00 AM does not ring.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            buzzer_q     <= 1'b0;
            snooze_cnt_q <= 2'd0;
            match_d_q    <= 1'b1;
        end else begin
            match_d_q <= match;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q      <= RINGING;
                        snooze_cnt_q <= 2'd0;
                        buzzer_q     <= 1'b1;
                    end
                end
                RINGING: begin
                    if (stop_req) begin
                        state_q  <= IDLE;
                        buzzer_q <= 1'b0;
                    end else if (snooze_ok) begin
                        state_q      <= SNOOZE;
                        snooze_cnt_q <= snooze_cnt_q + 2'd1;
                        buzzer_q     <= 1'b0;
                    end else if (timer_expire) begin
                        state_q  <= IDLE;
                        buzzer_q <= 1'b0;
                    end else if (sec_tick && (timer_cnt != '0)) begin
                        buzzer_q <= ~buzzer_q;
                    end
                end
                SNOOZE: begin
                    if (stop_req) begin
                        state_q  <= IDLE;
                        buzzer_q <= 1'b0;
                    end else if (timer_expire) begin
                        state_q  <= RINGING;
                        buzzer_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    buzzer_q <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer     = buzzer_q;
    assign ringing    = (state_q == RINGING);
    assign snoozing   = (state_q == SNOOZE);
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: vector table plus ring, snooze and reset sequences.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [3:0] cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones;
    logic       cur_pm;
    logic [3:0] alm_hr_tens, alm_hr_ones, alm_min_tens, alm_min_ones;
    logic       alm_pm;
    logic       alarm_en;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer, ringing, snoozing;
    logic [1:0] snooze_cnt;

    int total = 0;
    int bad   = 0;

    alarm_controller dut (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (sec_tick),
        .cur_hr_tens  (cur_hr_tens),
        .cur_hr_ones  (cur_hr_ones),
        .cur_min_tens (cur_min_tens),
        .cur_min_ones (cur_min_ones),
        .cur_pm       (cur_pm),
        .alm_hr_tens  (alm_hr_tens),
        .alm_hr_ones  (alm_hr_ones),
        .alm_min_tens (alm_min_tens),
        .alm_min_ones (alm_min_ones),
        .alm_pm       (alm_pm),
        .alarm_en     (alarm_en),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_cnt   (snooze_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {ringing, snoozing, buzzer, snooze_cnt[1:0]}.
    typedef struct {
        string       nm;
        logic [15:0] cur;
        logic        pm;
        logic        en;
        logic        snz;
        logic        stp;
        logic        tck;
        logic [4:0]  exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] outs();
        return {ringing, snoozing, buzzer, snooze_cnt};
    endfunction

    task automatic chk(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = outs();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got ring/snz/buz/cnt=%b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [15:0] t, input logic pm);
        cur_hr_tens  = t[15:12];
        cur_hr_ones  = t[11:8];
        cur_min_tens = t[7:4];
        cur_min_ones = t[3:0];
        cur_pm       = pm;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
        cyc();
    endtask

    task automatic pulse_snooze();
        snooze_btn = 1'b1;
        cyc();
        snooze_btn = 1'b0;
    endtask

    // Step 07:29 -> 07:30 AM so match rises and the alarm fires.
    task automatic fire(input string nm);
        set_cur(16'h0729, 1'b0);
        cyc();
        set_cur(16'h0730, 1'b0);
        cyc();
        chk(nm, 5'b10100);
    endtask

    initial begin
        reset = 1'b0; sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        alarm_en = 1'b1;
        set_cur(16'h1200, 1'b0);
        alm_hr_tens = 4'h1; alm_hr_ones = 4'h2; alm_min_tens = 4'h0; alm_min_ones = 4'h0;
        alm_pm = 1'b0;

        // Power-up with time and alarm both at 12:00 AM must not ring.
        #12;
        chk("reset_vals", 5'b00000);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sec_tick = (i % 5 == 0);
            cyc();
            chk("powerup_no_ring", 5'b00000);
        end
        sec_tick = 1'b0;

        alm_hr_tens = 4'h0; alm_hr_ones = 4'h7; alm_min_tens = 4'h3; alm_min_ones = 4'h0;
        alm_pm = 1'b0;

        tbl.push_back('{"idle_0729",    16'h0729, 0, 1, 0, 0, 0, 5'b00000});
        tbl.push_back('{"trigger",      16'h0730, 0, 1, 0, 0, 0, 5'b10100});
        tbl.push_back('{"tick_off",     16'h0730, 0, 1, 0, 0, 1, 5'b10000});
        tbl.push_back('{"tick_on",      16'h0730, 0, 1, 0, 0, 1, 5'b10100});
        tbl.push_back('{"snooze1",      16'h0730, 0, 1, 1, 0, 0, 5'b01001});
        tbl.push_back('{"snz_hold",     16'h0730, 0, 1, 0, 0, 1, 5'b01001});
        tbl.push_back('{"stop_snz",     16'h0730, 0, 1, 0, 1, 0, 5'b00001});
        tbl.push_back('{"no_retrig",    16'h0730, 0, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"pm_0729",      16'h0729, 1, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"pm_mismatch",  16'h0730, 1, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"hr_ones",      16'h0830, 0, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"hr_tens",      16'h1730, 0, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"min_tens",     16'h0720, 0, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"min_ones",     16'h0731, 0, 1, 0, 0, 0, 5'b00001});
        tbl.push_back('{"retrig_clr",   16'h0730, 0, 1, 0, 0, 0, 5'b10100});
        tbl.push_back('{"stop_and_snz", 16'h0730, 0, 1, 1, 1, 0, 5'b00000});
        tbl.push_back('{"en_off_idle",  16'h0729, 0, 0, 0, 0, 0, 5'b00000});
        tbl.push_back('{"en0_match",    16'h0730, 0, 0, 0, 0, 0, 5'b00000});
        tbl.push_back('{"en_rise",      16'h0730, 0, 1, 0, 0, 0, 5'b10100});
        tbl.push_back('{"en_off_ring",  16'h0730, 0, 0, 0, 0, 0, 5'b00000});
        tbl.push_back('{"en_rerise",    16'h0730, 0, 1, 0, 0, 0, 5'b10100});
        tbl.push_back('{"stop_ring",    16'h0730, 0, 1, 0, 1, 0, 5'b00000});

        foreach (tbl[i]) begin
            set_cur(tbl[i].cur, tbl[i].pm);
            alarm_en   = tbl[i].en;
            snooze_btn = tbl[i].snz;
            stop_btn   = tbl[i].stp;
            sec_tick   = tbl[i].tck;
            cyc();
            chk(tbl[i].nm, tbl[i].exp);
        end
        snooze_btn = 1'b0; stop_btn = 1'b0; sec_tick = 1'b0; alarm_en = 1'b1;

        // Full ring: buzzer toggles per tick, auto-stop exactly on tick RING_SECS.
        fire("ring_start");
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k < 60) chk($sformatf("ring_tick%0d", k), {1'b1, 1'b0, (k % 2 == 0), 2'b00});
            else        chk("ring_timeout", 5'b00000);
        end

        // Three snoozes of exactly SNOOZE_SECS ticks, fourth ignored, then stop+snooze.
        fire("snz_seq_start");
        for (int s = 1; s <= 3; s++) begin
            pulse_snooze();
            chk($sformatf("snooze_enter%0d", s), {3'b010, 2'(s)});
            for (int k = 0; k < 539; k++) tick();
            chk($sformatf("snooze_539_%0d", s), {3'b010, 2'(s)});
            tick();
            chk($sformatf("snooze_wake%0d", s), {3'b101, 2'(s)});
        end
        pulse_snooze();
        chk("snooze4_ignored", 5'b10111);
        tick();
        chk("ring_after_4th", 5'b10011);
        snooze_btn = 1'b1; stop_btn = 1'b1;
        cyc();
        snooze_btn = 1'b0; stop_btn = 1'b0;
        chk("stop_wins_cnt3", 5'b00011);

        // Disarming while snoozing returns to IDLE on the next edge.
        fire("en0_snz_start");
        pulse_snooze();
        chk("en0_snz_enter", 5'b01001);
        alarm_en = 1'b0;
        cyc();
        chk("en0_snz_idle", 5'b00001);
        set_cur(16'h0729, 1'b0);
        cyc();
        alarm_en = 1'b1;

        // Asynchronous reset mid-ring; the ongoing match must not re-ring afterwards.
        fire("rst_ring_start");
        tick();
        tick();
        chk("rst_ring_buz", 5'b10100);
        reset = 1'b0;
        #2;
        chk("async_reset", 5'b00000);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post_reset_no_ring", 5'b00000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
